scytale_encryption: RTL and testbench
=====================================

// Module: scytale_encryption
// PURPOSE
//  Scytale (transposition) encryptor: inverse of the team's scytale decryptor, same stream interface.
//  Buffers a plaintext of key_N*key_M chars, then emits the ciphertext one char per cycle.
//  Plaintext P is treated as key_N rows x key_M cols (row-major); ciphertext is P read column-wise:
//  E[r*key_N + j] = P[j*key_M + r], for r in 0..key_M-1 and j in 0..key_N-1.
//  Sits between the message source and the transmit path; the scytale decryptor restores P.
// PARAMETERS
//  D_WIDTH                 8      char width
//  KEY_WIDTH               8      width of key_N / key_M
//  MAX_NOF_CHARS           50     buffer depth (max message length)
//  START_ENCRYPTION_TOKEN  8'hFA  end-of-plaintext marker; starts encryption, never stored
//  PAD_CHAR                8'h20  emitted for buffer positions not written by the message
// PORTS
//  clk      in   1          clock, rising edge
//  rst_n    in   1          async reset, active low
//  data_i   in   D_WIDTH    plaintext char
//  valid_i  in   1          data_i qualifier
//  key_N    in   KEY_WIDTH  row count (chars emitted per ciphertext row)
//  key_M    in   KEY_WIDTH  column count (read stride)
//  data_o   out  D_WIDTH    ciphertext char; 0 when valid_o=0
//  valid_o  out  1          data_o qualifier
//  busy     out  1          high while encrypting; inputs ignored
// BEHAVIOUR
//  - One clock; async active-low reset. On reset: data_o=0, valid_o=0, busy=0, state COLLECT,
//    write count=0, all counters 0. Reset mid-emission aborts; no further valid_o.
//  - All outputs registered.
//  - COLLECT (busy=0): at edge with valid_i=1:
//    - data_i!=TOKEN: write buf[cnt], cnt++. If cnt==MAX_NOF_CHARS, the char is dropped.
//    - data_i==TOKEN: sample L=key_N*key_M, store copies of key_N/key_M.
//      - L==0 or L>MAX_NOF_CHARS: discard message (cnt=0), stay COLLECT, no output.
//      - otherwise: busy=1 after this edge, go to START.
//  - START (1 cycle): rd_idx=0, col=0, row=0, emitted=0. Go to EMIT. valid_o stays 0.
//  - EMIT: each edge drives valid_o=1, data_o=(rd_idx<cnt)?buf[rd_idx]:PAD_CHAR, then:
//    - emitted++.
//    - If col==key_N-1: col=0, row++, rd_idx=row+1 (next column start). Else col++, rd_idx+=key_M.
//    - After the edge that drives the L-th char, the next edge sets valid_o=0, data_o=0, busy=0,
//      cnt=0, and returns to COLLECT.
//  - Timing: token accepted at edge T -> busy=1 after T; chars valid after edges T+2..T+L+1;
//    valid_o/busy fall after edge T+L+2. valid_o is continuous (no gaps) for exactly L cycles.
//  - Keys are sampled only at token acceptance. Key changes during busy have no effect.
//  - valid_i while busy (START/EMIT) is ignored: no write, token not recognised.
//  - A new message may be accepted in the first cycle busy=0.
//  - rd_idx, cnt, and emitted widths: $clog2(MAX_NOF_CHARS+1). No per-cycle multiply;
//    L is computed once at token acceptance (2*KEY_WIDTH bits).
//  - Token as first char (cnt=0) with valid keys: emits L PAD_CHARs.
// TESTING
//  1. key_N=2, key_M=3, send 41 42 43 44 45 46 then FA
//     -> valid_o 6 consecutive cycles, data_o 41 44 42 45 43 46; busy low after.
//  2. key_N=2, key_M=2, send 41 42 then FA -> data_o 41 20 42 20 (padding).
//  3. key_N=0, key_M=5, send 41 then FA -> busy never rises, no valid_o; next message works normally.
//  4. During emission of case 1: drive valid_i=1 with 55 and FA, change keys
//     -> output unchanged; the 55 is not present in the next message.
//  5. Reset (rst_n=0) asynchronously after the 3rd output of case 1 -> valid_o/busy/data_o=0 immediately.
//     Then 41..46+FA -> full correct sequence.
//  6. key_N=5, key_M=10 (L=50 = max), 50 chars then FA -> 50 outputs, E[r*5+j]=P[j*10+r].
//     Decryptor round trip restores P.

Source files
------------

// File: rtl/scytale_encryption.sv
// Scytale transposition encryptor.
// Collects a plaintext (row-major, key_N rows x key_M columns) until the
// start token arrives, then streams the plaintext out column by column,
// one char per cycle. Positions never written by the message come out as
// PAD_CHAR. The matching scytale decryptor restores the original text.
module scytale_encryption #(
  parameter int                   D_WIDTH                = 8,
  parameter int                   KEY_WIDTH              = 8,
  parameter int                   MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = 8'hFA,
  parameter logic [D_WIDTH-1:0]   PAD_CHAR               = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int IDX_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int LEN_W = 2 * KEY_WIDTH;
  localparam int SUM_W = IDX_W + KEY_WIDTH;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_START,
    S_EMIT
  } state_t;

  // Message buffer, no reset: positions beyond the write count are padded.
  logic [D_WIDTH-1:0] buf_mem [MAX_NOF_CHARS];

  state_t               state_reg,   state_next;
  logic [IDX_W-1:0]     cnt_reg,     cnt_next;
  logic [LEN_W-1:0]     len_reg,     len_next;
  logic [KEY_WIDTH-1:0] key_n_reg,   key_n_next;
  logic [KEY_WIDTH-1:0] key_m_reg,   key_m_next;
  logic [IDX_W-1:0]     rd_idx_reg,  rd_idx_next;
  logic [KEY_WIDTH-1:0] col_reg,     col_next;
  logic [KEY_WIDTH-1:0] row_reg,     row_next;
  logic [IDX_W-1:0]     emitted_reg, emitted_next;
  logic [D_WIDTH-1:0]   data_reg,    data_next;
  logic                 valid_reg,   valid_next;
  logic                 busy_reg,    busy_next;

  logic                 buf_we;
  logic [LEN_W-1:0]     len_in;

  // Message length is formed once, only when the token is taken.
  assign len_in = LEN_W'(key_N) * LEN_W'(key_M);

  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign busy    = busy_reg;

  // Next-state logic: collection, key capture and column-wise read-out.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    key_n_next   = key_n_reg;
    key_m_next   = key_m_reg;
    rd_idx_next  = rd_idx_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    emitted_next = emitted_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    busy_next    = busy_reg;
    buf_we       = 1'b0;

    case (state_reg)
      S_COLLECT: begin
        if (valid_i) begin
          if (data_i == START_ENCRYPTION_TOKEN) begin
            key_n_next = key_N;
            key_m_next = key_M;
            len_next   = len_in;
            if ((len_in == '0) || (len_in > LEN_W'(MAX_NOF_CHARS))) begin
              // Unusable key pair: throw the message away.
              cnt_next = '0;
            end else begin
              busy_next  = 1'b1;
              state_next = S_START;
            end
          end else if (cnt_reg < IDX_W'(MAX_NOF_CHARS)) begin
            // Chars beyond the buffer depth are silently dropped.
            buf_we   = 1'b1;
            cnt_next = cnt_reg + IDX_W'(1);
          end
        end
      end

      S_START: begin
        rd_idx_next  = '0;
        col_next     = '0;
        row_next     = '0;
        emitted_next = '0;
        state_next   = S_EMIT;
      end

      S_EMIT: begin
        if (LEN_W'(emitted_reg) == len_reg) begin
          // Whole ciphertext sent: release the stream and clear the buffer.
          valid_next = 1'b0;
          data_next  = '0;
          busy_next  = 1'b0;
          cnt_next   = '0;
          state_next = S_COLLECT;
        end else begin
          valid_next   = 1'b1;
          data_next    = (rd_idx_reg < cnt_reg) ? buf_mem[rd_idx_reg] : PAD_CHAR;
          emitted_next = emitted_reg + IDX_W'(1);
          if (col_reg == key_n_reg - KEY_WIDTH'(1)) begin
            // End of a ciphertext row: jump to the top of the next column.
            col_next    = '0;
            row_next    = row_reg + KEY_WIDTH'(1);
            rd_idx_next = IDX_W'(row_reg + KEY_WIDTH'(1));
          end else begin
            // Walk down the current column by one plaintext row.
            col_next    = col_reg + KEY_WIDTH'(1);
            rd_idx_next = IDX_W'(SUM_W'(rd_idx_reg) + SUM_W'(key_m_reg));
          end
        end
      end

      default: begin
        state_next = S_COLLECT;
      end
    endcase
  end

  // Control and output registers; reset aborts any emission immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_COLLECT;
      cnt_reg     <= '0;
      len_reg     <= '0;
      key_n_reg   <= '0;
      key_m_reg   <= '0;
      rd_idx_reg  <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      emitted_reg <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      key_n_reg   <= key_n_next;
      key_m_reg   <= key_m_next;
      rd_idx_reg  <= rd_idx_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      emitted_reg <= emitted_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
    end
  end

  // Plaintext buffer write port.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[cnt_reg] <= data_i;
    end
  end

endmodule

// File: tb/tb_scytale_encryption.sv
// Self-checking bench for scytale_encryption: directed scenarios plus
// randomized back-to-back messages against a matrix-based reference model.
module tb_scytale_encryption;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  scytale_encryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] msg_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         first_cyc;
  bit         ctrl_ok;
  bit         done_flag;

  // Drive one char for one clock edge (called at posedge+1).
  task automatic send_char(input logic [7:0] c);
    data_i  = c;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  // Set keys, send msg_q, then the token.
  task automatic send_msg(input int n, input int m);
    key_N = 8'(n);
    key_M = 8'(m);
    foreach (msg_q[i]) send_char(msg_q[i]);
    send_char(8'hFA);
  endtask

  // Reference: plaintext is an n x m row-major matrix (only the first 50
  // chars fit), ciphertext is that matrix read column by column.
  task automatic model(input int n, input int m);
    int stored;
    int r;
    int j;
    exp_q = {};
    if (n * m == 0 || n * m > 50) return;
    stored = (msg_q.size() > 50) ? 50 : msg_q.size();
    for (int e = 0; e < n * m; e++) begin
      r = e / n;
      j = e % n;
      exp_q.push_back((j * m + r < stored) ? msg_q[j * m + r] : 8'h20);
    end
  endtask

  // Record the output stream after a token; first sample is edge T+1.
  task automatic collect(input int budget);
    obs_q     = {};
    first_cyc = -1;
    ctrl_ok   = 1'b1;
    done_flag = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (valid_o === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        obs_q.push_back(data_o);
        if (busy !== 1'b1) ctrl_ok = 1'b0;
      end else begin
        if (data_o !== 8'h00) ctrl_ok = 1'b0;
        if (first_cyc >= 0) begin
          if (busy !== 1'b0) ctrl_ok = 1'b0;
          done_flag = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic rand_msg(input int len);
    logic [7:0] c;
    msg_q = {};
    for (int i = 0; i < len; i++) begin
      c = 8'($urandom_range(0, 255));
      if (c == 8'hFA) c = 8'h00;
      msg_q.push_back(c);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data_o: got %h expected 00", data_o); end
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid_o: got %b expected 0", valid_o); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] lit [6];
    lit = '{8'h41, 8'h44, 8'h42, 8'h45, 8'h43, 8'h46};
    msg_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    send_msg(2, 3);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    collect(20);
    n_cmp++;
    if (first_cyc !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d expected 2", first_cyc); end
    n_cmp++;
    if (obs_q.size() !== 6) begin n_bad++; $display("FAIL basic_count: got %0d expected 6", obs_q.size()); end
    n_cmp++;
    if (!(ctrl_ok && done_flag)) begin n_bad++; $display("FAIL basic_ctrl: got ok=%b done=%b expected 1/1", ctrl_ok, done_flag); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== lit[i]) begin
        n_bad++;
        $display("FAIL basic_char[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, lit[i]);
      end
    end
  endtask

  task automatic test_padding();
    logic [7:0] lit [4];
    lit = '{8'h41, 8'h20, 8'h42, 8'h20};
    msg_q = {8'h41, 8'h42};
    send_msg(2, 2);
    collect(20);
    n_cmp++;
    if (obs_q.size() !== 4 || !ctrl_ok || !done_flag) begin
      n_bad++; $display("FAIL pad_count: got %0d ok=%b expected 4 ok=1", obs_q.size(), ctrl_ok);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== lit[i]) begin
        n_bad++; $display("FAIL pad_char[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, lit[i]);
      end
    end
    // Token as the very first char: all padding.
    msg_q = {};
    send_msg(1, 3);
    collect(20);
    n_cmp++;
    if (obs_q.size() !== 3 || !ctrl_ok) begin
      n_bad++; $display("FAIL pad_empty_count: got %0d expected 3", obs_q.size());
    end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== 8'h20) begin n_bad++; $display("FAIL pad_empty_char[%0d]: got %h expected 20", i, obs_q[i]); end
    end
  endtask

  task automatic test_invalid_keys();
    msg_q = {8'h41};
    send_msg(0, 5);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL inv_zero_busy: got %b expected 0", busy); end
    collect(8);
    n_cmp++;
    if (obs_q.size() !== 0) begin n_bad++; $display("FAIL inv_zero_out: got %0d chars expected 0", obs_q.size()); end
    msg_q = {8'h41, 8'h42};
    send_msg(8, 7);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL inv_big_busy: got %b expected 0", busy); end
    collect(8);
    n_cmp++;
    if (obs_q.size() !== 0) begin n_bad++; $display("FAIL inv_big_out: got %0d chars expected 0", obs_q.size()); end
    // Discarded chars must not leak into the next message.
    msg_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    model(2, 3);
    send_msg(2, 3);
    collect(20);
    n_cmp++;
    if (obs_q.size() !== exp_q.size() || !ctrl_ok) begin
      n_bad++; $display("FAIL inv_next_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL inv_next_char[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    msg_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    model(2, 3);
    send_msg(2, 3);
    fork
      collect(20);
      begin
        @(posedge clk); #1;
        data_i = 8'h55; valid_i = 1'b1; key_N = 8'd7; key_M = 8'd7;
        @(posedge clk); #1;
        data_i = 8'hFA; key_N = 8'd0;
        @(posedge clk); #1;
        data_i = 8'h55; key_M = 8'd1;
        @(posedge clk); #1;
        valid_i = 1'b0; data_i = 8'h00;
      end
    join
    n_cmp++;
    if (obs_q.size() !== 6 || !ctrl_ok || !done_flag) begin
      n_bad++; $display("FAIL ign_count: got %0d ok=%b expected 6 ok=1", obs_q.size(), ctrl_ok);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ign_char[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
    msg_q = {8'h41, 8'h42};
    model(2, 2);
    send_msg(2, 2);
    collect(20);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL ign_next_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ign_next_char[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    msg_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    send_msg(2, 3);
    collect(4);
    n_cmp++;
    if (obs_q.size() !== 3 || obs_q[0] !== 8'h41 || obs_q[1] !== 8'h44 || obs_q[2] !== 8'h42) begin
      n_bad++; $display("FAIL arst_prefix: got %0d chars expected 41 44 42", obs_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid_o, busy, data_o} !== 10'd0) begin
      n_bad++; $display("FAIL arst_immediate: got valid=%b busy=%b data=%h expected 0 0 00", valid_o, busy, data_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_o, busy, data_o} !== 10'd0) begin
      n_bad++; $display("FAIL arst_hold: got valid=%b busy=%b data=%h expected 0 0 00", valid_o, busy, data_o);
    end
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL arst_no_resume: got valid=%b expected 0", valid_o); end
    model(2, 3);
    send_msg(2, 3);
    collect(20);
    n_cmp++;
    if (obs_q.size() !== 6 || !ctrl_ok || first_cyc !== 2) begin
      n_bad++; $display("FAIL arst_rerun_count: got %0d first=%0d expected 6 first=2", obs_q.size(), first_cyc);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL arst_rerun_char[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_max_roundtrip(input int nchars);
    logic [7:0] dec [50];
    rand_msg(nchars);
    model(5, 10);
    send_msg(5, 10);
    collect(70);
    n_cmp++;
    if (obs_q.size() !== 50 || !ctrl_ok || !done_flag) begin
      n_bad++; $display("FAIL max_count(%0d): got %0d ok=%b expected 50 ok=1", nchars, obs_q.size(), ctrl_ok);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL max_char(%0d)[%0d]: got %h expected %h", nchars, i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
    // Decryptor view: D[j*M+r] = E[r*N+j] must restore the first 50 chars.
    if (obs_q.size() == 50) begin
      for (int r = 0; r < 10; r++)
        for (int j = 0; j < 5; j++)
          dec[j * 10 + r] = obs_q[r * 5 + j];
      for (int i = 0; i < 50; i++) begin
        n_cmp++;
        if (dec[i] !== msg_q[i]) begin
          n_bad++; $display("FAIL roundtrip(%0d)[%0d]: got %h expected %h", nchars, i, dec[i], msg_q[i]);
        end
      end
    end
  endtask

  task automatic test_random_back_to_back();
    int n;
    int m;
    bit ok;
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 8);
      m = $urandom_range(0, 8);
      ok = (n * m != 0) && (n * m <= 50);
      rand_msg($urandom_range(0, 55));
      model(n, m);
      send_msg(n, m);
      n_cmp++;
      if (busy !== ok) begin n_bad++; $display("FAIL rnd%0d_busy: got %b expected %b", it, busy, ok); end
      collect(ok ? n * m + 5 : 6);
      n_cmp++;
      if (obs_q.size() !== exp_q.size() || !ctrl_ok || (ok && (first_cyc !== 2 || !done_flag))) begin
        n_bad++; $display("FAIL rnd%0d_stream N=%0d M=%0d: got %0d chars first=%0d ok=%b expected %0d first=2",
                          it, n, m, obs_q.size(), first_cyc, ctrl_ok, exp_q.size());
      end
      foreach (exp_q[i]) begin
        n_cmp++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rnd%0d_char[%0d]: got %h expected %h", it, i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_N   = 8'd0;
    key_M   = 8'd0;
    #12;
    test_reset();
    #8;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_padding();
    test_invalid_keys();
    test_busy_ignore();
    test_async_reset();
    test_max_roundtrip(50);
    test_max_roundtrip(53);
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
